// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store/writeback stage.
package lsu_pkg;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned TIMEOUT_W = 0;
  localparam int unsigned BE_W      = XLEN / 8;
  localparam int unsigned REG_AW    = 5;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    WB_ALU  = 2'd0,
    WB_LOAD = 2'd1,
    WB_PC4  = 2'd2,
    WB_CSR  = 2'd3
  } wb_sel_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } lsu_state_e;

  typedef struct packed {
    logic [XLEN-1:0]   addr;
    logic [1:0]        lane;
    logic [BE_W-1:0]   be;
    logic [XLEN-1:0]   wdata;
    logic              we;
    logic [2:0]        funct3;
    logic [REG_AW-1:0] rd;
  } mem_req_t;

  // Access size is carried by funct3[1:0] for both loads and stores.
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] lo);
    return ((f3[1:0] == F3_SH[1:0]) && lo[0]) || (f3[1] && (lo != 2'b00));
  endfunction

  function automatic logic [1:0] align_lo(input logic [2:0] f3, input logic [1:0] lo);
    case (f3[1:0])
      F3_SB[1:0]: return lo;
      F3_SH[1:0]: return {lo[1], 1'b0};
      default:    return 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/load_align.sv
// Extracts the addressed lane from a load word and sign/zero-extends it.
module load_align
  import lsu_pkg::*;
(
  input  logic [XLEN-1:0] rdata,
  input  logic [1:0]      lane,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] word_c
);

  logic [XLEN-1:0] shifted;

  assign shifted = rdata >> {lane, 3'b000};

  always_comb begin
    word_c = rdata;
    case (funct3)
      F3_LB:   word_c = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
      F3_LBU:  word_c = {{(XLEN-8){1'b0}}, shifted[7:0]};
      F3_LH:   word_c = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
      F3_LHU:  word_c = {{(XLEN-16){1'b0}}, shifted[15:0]};
      F3_LW:   word_c = rdata;
      default: word_c = rdata;
    endcase
  end

endmodule

// File: rtl/load_store_wb.sv
// Memory/writeback stage: data-bus load/store FSM plus register-file writeback.
// MISALIGN_TRAP_EN: trap misaligned half/word accesses instead of forcing alignment.
module load_store_wb
  import lsu_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_i,
  input  logic              flush_i,
  input  logic              mem_op_i,
  input  logic              mem_we_i,
  input  logic [2:0]        funct3_i,
  input  logic [XLEN-1:0]   addr_i,
  input  logic [XLEN-1:0]   store_data_i,
  input  logic [1:0]        wb_sel_i,
  input  logic [XLEN-1:0]   alu_res_i,
  input  logic [XLEN-1:0]   pc4_i,
  input  logic [XLEN-1:0]   csr_rdata_i,
  input  logic [REG_AW-1:0] rd_addr_i,
  input  logic              rd_wr_i,
  output logic              stall_o,
  output logic              dmem_req_o,
  output logic              dmem_we_o,
  output logic [BE_W-1:0]   dmem_be_o,
  output logic [XLEN-1:0]   dmem_addr_o,
  output logic [XLEN-1:0]   dmem_wdata_o,
  input  logic              dmem_gnt_i,
  input  logic              dmem_rvalid_i,
  input  logic [XLEN-1:0]   dmem_rdata_i,
  output logic [XLEN-1:0]   wdata_o,
  output logic [REG_AW-1:0] waddr_o,
  output logic              reg_wr_c,
  output logic              misalign_o,
  output logic [XLEN-1:0]   misalign_addr_o
);

  lsu_state_e      state_q, state_d;
  mem_req_t        req_q, req_d;
  logic            legal, done, wb_accept, mem_valid;
  logic [1:0]      lane;
  logic [BE_W-1:0] be_c;
  logic [XLEN-1:0] st_data_c, load_word, wb_mux;

  assign mem_valid = valid_i & mem_op_i & ~flush_i;
  assign lane      = align_lo(funct3_i, addr_i[1:0]);

`ifdef MISALIGN_TRAP_EN
  assign legal = ~is_misaligned(funct3_i, addr_i[1:0]);
`else
  assign legal = 1'b1;
`endif

  // Byte enables and lane-replicated store data for the (aligned) access.
  always_comb begin
    be_c      = BE_W'(4'b1111);
    st_data_c = store_data_i;
    case (funct3_i[1:0])
      F3_SB[1:0]: begin
        be_c      = BE_W'(4'b0001 << lane);
        st_data_c = {4{store_data_i[7:0]}};
      end
      F3_SH[1:0]: begin
        be_c      = BE_W'(4'b0011 << lane);
        st_data_c = {2{store_data_i[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    done      = 1'b0;
    wb_accept = 1'b0;
    case (state_q)
      IDLE: begin
        wb_accept = valid_i & ~mem_op_i & rd_wr_i & ~flush_i;
        if (mem_valid && legal) begin
          state_d      = REQ;
          req_d.addr   = {addr_i[XLEN-1:2], 2'b00};
          req_d.lane   = lane;
          req_d.be     = be_c;
          req_d.wdata  = st_data_c;
          req_d.we     = mem_we_i;
          req_d.funct3 = funct3_i;
          req_d.rd     = rd_addr_i;
        end
      end
      REQ: begin
        if (dmem_gnt_i) begin
          state_d = req_q.we ? IDLE : WAIT;
          done    = req_q.we;
        end
      end
      WAIT: begin
        if (dmem_rvalid_i) begin
          state_d = IDLE;
          done    = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    stall_o = mem_valid & legal & ~done;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      req_q   <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
    end
  end

  assign dmem_req_o   = (state_q == REQ);
  assign dmem_we_o    = req_q.we;
  assign dmem_be_o    = req_q.be;
  assign dmem_addr_o  = req_q.addr;
  assign dmem_wdata_o = req_q.wdata;

  load_align u_load_align (
    .rdata  (dmem_rdata_i),
    .lane   (req_q.lane),
    .funct3 (req_q.funct3),
    .word_c (load_word)
  );

  always_comb begin
    case (wb_sel_e'(wb_sel_i))
      WB_PC4:  wb_mux = pc4_i;
      WB_CSR:  wb_mux = csr_rdata_i;
      default: wb_mux = alu_res_i;
    endcase
  end

  // Writeback register; x0 is never written.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wdata_o  <= '0;
      waddr_o  <= '0;
      reg_wr_c <= 1'b0;
    end else begin
      reg_wr_c <= 1'b0;
      if (state_q == WAIT && dmem_rvalid_i) begin
        wdata_o  <= load_word;
        waddr_o  <= req_q.rd;
        reg_wr_c <= |req_q.rd;
      end else if (wb_accept) begin
        wdata_o  <= wb_mux;
        waddr_o  <= rd_addr_i;
        reg_wr_c <= |rd_addr_i;
      end
    end
  end

`ifdef MISALIGN_TRAP_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      misalign_o      <= 1'b0;
      misalign_addr_o <= '0;
    end else begin
      misalign_o <= (state_q == IDLE) & mem_valid & ~legal;
      if ((state_q == IDLE) && mem_valid && !legal) begin
        misalign_addr_o <= addr_i;
      end
    end
  end
`else
  assign misalign_o      = 1'b0;
  assign misalign_addr_o = '0;
`endif

endmodule
